mips_multicycle_control: RTL and testbench

- Main control FSM for the multicycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives all datapath enables and mux selects, and produces the 3-bit ALUOP consumed by the ALU control stage.
- Handles variable-latency memory through a ready handshake, with a watchdog timeout.

---
 rtl/mips_multicycle_control.sv | 247 ++++++++++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_control
// Purpose  : Main control FSM for a multicycle MIPS datapath. Sequences each
//            instruction through fetch/decode/execute/memory/writeback,
//            drives datapath enables and mux selects, and produces the 3-bit
//            ALUOP class for the ALU control stage. Memory accesses complete
//            on a mem_ready handshake guarded by a watchdog timeout.
// Ports    : clk, rst_n (async, active-low)
//            opcode      - IR[31:26], sampled in DECODE only
//            mem_ready   - memory completes current access this cycle
//            PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
//            MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB[1:0],
//            PCSource[1:0], ALUOP[2:0] - datapath controls
//            illegal_op  - one-cycle pulse on unsupported opcode in DECODE
//            mem_err     - one-cycle pulse on watchdog expiry
//            state_o     - current state code (debug)
// Revision : 1.0 - initial release
// ============================================================================
module mips_multicycle_control #(
  parameter int TIMEOUT = 16,  // max cycles waiting for mem_ready; 0 = off
  parameter int TW      = 5    // watchdog width, 2^TW > TIMEOUT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [2:0] ALUOP,
  output logic       illegal_op,
  output logic       mem_err,
  output logic [3:0] state_o
);

  // State encoding (visible on state_o)
  localparam logic [3:0] S_RESET  = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD  = 4'd4;
  localparam logic [3:0] S_MEMWB  = 4'd5;
  localparam logic [3:0] S_MEMWR  = 4'd6;
  localparam logic [3:0] S_REX    = 4'd7;
  localparam logic [3:0] S_RWB    = 4'd8;
  localparam logic [3:0] S_IEX    = 4'd9;
  localparam logic [3:0] S_IWB    = 4'd10;
  localparam logic [3:0] S_BR     = 4'd11;
  localparam logic [3:0] S_JMP    = 4'd12;

  // Supported opcodes
  localparam logic [5:0] C_OP_RTYPE = 6'h00;
  localparam logic [5:0] C_OP_J     = 6'h02;
  localparam logic [5:0] C_OP_BEQ   = 6'h04;
  localparam logic [5:0] C_OP_BNE   = 6'h05;
  localparam logic [5:0] C_OP_ADDI  = 6'h08;
  localparam logic [5:0] C_OP_ANDI  = 6'h0C;
  localparam logic [5:0] C_OP_ORI   = 6'h0D;
  localparam logic [5:0] C_OP_LW    = 6'h23;
  localparam logic [5:0] C_OP_SW    = 6'h2B;

  localparam bit              C_WDOG_EN   = (TIMEOUT > 0);
  localparam logic [TW-1:0]   C_WDOG_LIM  = TW'(TIMEOUT);

  logic [3:0]    state_q, state_d;
  logic [5:0]    op_q, op_d;
  logic [TW-1:0] wdog_q, wdog_d;

  logic w_wait_state;
  logic w_timeout;
  logic w_legal;

  // States that wait on the memory handshake
  assign w_wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                        (state_q == S_MEMWR);

  // mem_ready has priority over expiry in the same cycle
  assign w_timeout = C_WDOG_EN && w_wait_state && !mem_ready &&
                     (wdog_q == C_WDOG_LIM);

  // Counter only holds a non-zero value while stalled in a wait state, so it
  // is implicitly cleared on entry to any wait state.
  assign wdog_d = (C_WDOG_EN && w_wait_state && !mem_ready && !w_timeout) ?
                  wdog_q + TW'(1) : '0;

  always_comb begin
    w_legal = 1'b0;
    case (opcode)
      C_OP_RTYPE, C_OP_J, C_OP_BEQ, C_OP_BNE, C_OP_ADDI,
      C_OP_ANDI, C_OP_ORI, C_OP_LW, C_OP_SW: w_legal = 1'b1;
      default:                               w_legal = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RESET;
      op_q    <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wdog_q  <= wdog_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        op_d = opcode;
        case (opcode)
          C_OP_RTYPE:                    state_d = S_REX;
          C_OP_LW, C_OP_SW:              state_d = S_MEMADR;
          C_OP_BEQ, C_OP_BNE:            state_d = S_BR;
          C_OP_J:                        state_d = S_JMP;
          C_OP_ADDI, C_OP_ANDI, C_OP_ORI: state_d = S_IEX;
          default:                       state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (op_q == C_OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (mem_ready)      state_d = S_MEMWB;
        else if (w_timeout) state_d = S_FETCH;
        else                state_d = S_MEMRD;
      end
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR: begin
        if (mem_ready || w_timeout) state_d = S_FETCH;
        else                        state_d = S_MEMWR;
      end
      S_REX:    state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_IEX:    state_d = S_IWB;
      S_IWB:    state_d = S_FETCH;
      S_BR:     state_d = S_FETCH;
      S_JMP:    state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------------
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALUOP       = 3'b000;
    illegal_op  = 1'b0;
    mem_err     = w_timeout;
    case (state_q)
      S_FETCH: begin
        // PC+4 computed in the ALU while the instruction is read
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        // Speculative branch target into ALUOut
        ALUSrcB    = 2'b11;
        illegal_op = !w_legal;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_REX: begin
        ALUSrcA = 1'b1;
        ALUOP   = 3'b010;
      end
      S_RWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_IEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        case (op_q)
          C_OP_ANDI: ALUOP = 3'b011;
          C_OP_ORI:  ALUOP = 3'b100;
          default:   ALUOP = 3'b000;
        endcase
      end
      S_IWB: begin
        RegWrite = 1'b1;
      end
      S_BR: begin
        ALUSrcA     = 1'b1;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        ALUOP       = (op_q == C_OP_BNE) ? 3'b111 : 3'b001;
      end
      S_JMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      default: ;
    endcase
  end

  assign state_o = state_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_control.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mips_multicycle_control
// Purpose  : Self-checking bench for mips_multicycle_control. An
//            instruction-level model expands each opcode and chosen memory
//            latency into the expected per-cycle control vector.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_control;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOP;
  logic       illegal_op, mem_err;
  logic [3:0] state_o;

  int checks   = 0;
  int failures = 0;

  mips_multicycle_control #(.TIMEOUT(TO), .TW(3)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUOP(ALUOP), .illegal_op(illegal_op), .mem_err(mem_err),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
    logic [1:0] asb, pcs;
    logic [2:0] aluop;
    logic       ill, merr;
  } exp_t;

  function automatic exp_t mk(input logic [3:0] s);
    exp_t e;
    e = '0;
    e.st = s;
    return e;
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D,
                      6'h23, 6'h2B};
  endfunction

  task automatic check(input exp_t e, input string tag);
    exp_t o;
    o = {state_o, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
         MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOP,
         illegal_op, mem_err};
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // One clock cycle: drive inputs on the falling edge, compare 1ns later
  task automatic step(input exp_t e, input logic rdy, input logic [5:0] opv,
                      input string tag);
    @(negedge clk);
    mem_ready = rdy;
    opcode    = opv;
    #1;
    check(e, tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check(mk(4'd0), "rst_async");
    repeat (2) begin
      @(negedge clk);
      mem_ready = 1'($urandom);
      opcode    = 6'($urandom);
      #1;
      check(mk(4'd0), "rst_hold");
    end
    @(negedge clk);
    rst_n     = 1'b1;
    mem_ready = 1'($urandom);
    #1;
    check(mk(4'd0), "rst_release");
  endtask

  // Memory-handshake phase: ready held low for w cycles, then high.
  // Ready arriving while the watchdog is at its limit still completes.
  task automatic mem_access(input exp_t base, input bit is_fetch, input int w,
                            input string tag, output bit ok);
    exp_t e;
    ok = 1'b0;
    for (int i = 0; i <= TO; i++) begin
      e = base;
      if (i >= w) begin
        if (is_fetch) begin
          e.irw = 1'b1;
          e.pcw = 1'b1;
        end
        step(e, 1'b1, 6'($urandom), tag);
        ok = 1'b1;
        return;
      end
      if (i == TO) begin
        e.merr = 1'b1;
        step(e, 1'b0, 6'($urandom), {tag, "_timeout"});
        return;
      end
      step(e, 1'b0, 6'($urandom), tag);
    end
  endtask

  function automatic exp_t e_fetch();
    exp_t e;
    e = mk(4'd1);
    e.mrd = 1'b1;
    e.asb = 2'b01;
    return e;
  endfunction

  function automatic exp_t e_decode(input logic [5:0] op);
    exp_t e;
    e = mk(4'd2);
    e.asb = 2'b11;
    e.ill = !is_legal(op);
    return e;
  endfunction

  function automatic exp_t e_memadr();
    exp_t e;
    e = mk(4'd3);
    e.asa = 1'b1;
    e.asb = 2'b10;
    return e;
  endfunction

  function automatic exp_t e_memrd();
    exp_t e;
    e = mk(4'd4);
    e.mrd  = 1'b1;
    e.iord = 1'b1;
    return e;
  endfunction

  // Full instruction: fw = fetch wait cycles, mw = data-access wait cycles
  task automatic do_instr(input logic [5:0] op, input int fw, input int mw);
    bit   ok;
    exp_t e;
    mem_access(e_fetch(), 1'b1, fw, "fetch", ok);
    if (!ok) return;
    step(e_decode(op), 1'($urandom), op, "decode");
    if (!is_legal(op)) return;
    case (op)
      6'h23: begin
        step(e_memadr(), 1'($urandom), 6'($urandom), "lw_memadr");
        mem_access(e_memrd(), 1'b0, mw, "lw_memrd", ok);
        if (ok) begin
          e = mk(4'd5); e.m2r = 1'b1; e.rw = 1'b1;
          step(e, 1'($urandom), 6'($urandom), "lw_memwb");
        end
      end
      6'h2B: begin
        step(e_memadr(), 1'($urandom), 6'($urandom), "sw_memadr");
        e = mk(4'd6); e.mwr = 1'b1; e.iord = 1'b1;
        mem_access(e, 1'b0, mw, "sw_memwr", ok);
      end
      6'h00: begin
        e = mk(4'd7); e.asa = 1'b1; e.aluop = 3'b010;
        step(e, 1'($urandom), 6'($urandom), "rex");
        e = mk(4'd8); e.rdst = 1'b1; e.rw = 1'b1;
        step(e, 1'($urandom), 6'($urandom), "rwb");
      end
      6'h08, 6'h0C, 6'h0D: begin
        e = mk(4'd9); e.asa = 1'b1; e.asb = 2'b10;
        e.aluop = (op == 6'h0C) ? 3'b011 : (op == 6'h0D) ? 3'b100 : 3'b000;
        step(e, 1'($urandom), 6'($urandom), "iex");
        e = mk(4'd10); e.rw = 1'b1;
        step(e, 1'($urandom), 6'($urandom), "iwb");
      end
      6'h04, 6'h05: begin
        e = mk(4'd11); e.asa = 1'b1; e.pcwc = 1'b1; e.pcs = 2'b01;
        e.aluop = (op == 6'h04) ? 3'b001 : 3'b111;
        step(e, 1'($urandom), 6'($urandom), "br");
      end
      default: begin // jump
        e = mk(4'd12); e.pcw = 1'b1; e.pcs = 2'b10;
        step(e, 1'($urandom), 6'($urandom), "jmp");
      end
    endcase
  endtask

  initial begin
    bit          ok;
    logic [5:0]  legal_ops [9];
    logic [5:0]  op;
    legal_ops = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D,
                  6'h23, 6'h2B};

    do_reset();
    // Directed instruction mix
    do_instr(6'h23, 0, 0);        // lw, no waits
    do_instr(6'h00, 0, 0);        // R-type
    do_instr(6'h08, 0, 0);        // addi
    do_instr(6'h04, 0, 0);        // beq
    do_instr(6'h05, 0, 0);        // bne
    do_instr(6'h0C, 0, 0);        // andi
    do_instr(6'h0D, 0, 0);        // ori
    do_instr(6'h2B, 0, 3);        // sw, 3 wait cycles
    do_instr(6'h02, 2, 0);        // j, fetch stalls 2 cycles
    do_instr(6'h23, 0, TO + 3);   // lw, read times out
    do_instr(6'h23, 0, TO);       // lw, ready at the limit cycle wins
    do_instr(6'h2B, 0, TO + 1);   // sw, write times out
    do_instr(6'h3F, 0, 0);        // illegal opcode
    do_instr(6'h00, TO + 1, 0);   // fetch times out, instruction dropped
    do_instr(6'h00, 0, 0);

    // Reset asserted while stalled in MEMRD
    mem_access(e_fetch(), 1'b1, 0, "fetch", ok);
    step(e_decode(6'h23), 1'b1, 6'h23, "decode");
    step(e_memadr(), 1'b0, 6'h00, "lw_memadr");
    step(e_memrd(), 1'b0, 6'h00, "lw_memrd");
    do_reset();

    // Randomized instruction stream
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        op = 6'($urandom);
        if (is_legal(op)) op = 6'h3F;
      end else begin
        op = legal_ops[$urandom_range(0, 8)];
      end
      do_instr(op,
               ($urandom_range(0, 9) == 0) ? $urandom_range(0, TO + 2)
                                           : $urandom_range(0, 2),
               $urandom_range(0, TO + 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
